// File: rtl/gdp_pkg.sv
// gdp_pkg: shared types and constants for the gdp sequencer.
//   state_t  - sequencer FSM states
//   op_t     - command op codes
//   ALU_*/SH_* - datapath function codes
//   R0..R3   - register file addresses
//   cw_t     - packed datapath control word
package gdp_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LDA, S_LDN, S_BODY, S_DEC, S_OUT, S_ERR
    } state_t;

    typedef enum logic [1:0] {OP_SUM, OP_MULT, OP_POW2, OP_ILL} op_t;

    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_AND   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_NOTA  = 3'b011;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b101;
    localparam logic [2:0] ALU_INC   = 3'b110;
    localparam logic [2:0] ALU_DEC   = 3'b111;

    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_SHL  = 2'b01;
    localparam logic [1:0] SH_SHR  = 2'b10;
    localparam logic [1:0] SH_ROTR = 2'b11;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;
    localparam logic [1:0] R3 = 2'd3;

    typedef struct packed {
        logic       ie;
        logic       we;
        logic [1:0] wa;
        logic       rae;
        logic [1:0] raa;
        logic       rbe;
        logic [1:0] rba;
        logic [2:0] alu;
        logic [1:0] sh;
        logic       oe;
    } cw_t;

    // MULT keeps a in R1, so its running sum lives in R2.
    function automatic logic [1:0] acc_reg(input op_t op);
        return op == OP_MULT ? R2 : R1;
    endfunction

endpackage

// File: rtl/gdp_cw_decode.sv
// gdp_cw_decode: Moore decode of (state, latched op) into the datapath control word.
//   i_state  - current sequencer state
//   i_op     - latched op
//   o_cw     - datapath control word
//   o_ld_idx - operand index the host must present while IE=1
module gdp_cw_decode
    import gdp_pkg::*;
(
    input  state_t i_state,
    input  op_t    i_op,
    output cw_t    o_cw,
    output logic   o_ld_idx
);

    logic [1:0] w_acc;
    logic       w_pow2;

    assign w_acc  = acc_reg(i_op);
    assign w_pow2 = i_op == OP_POW2;

    always_comb begin
        o_cw     = '0;
        o_ld_idx = 1'b0;
        case (i_state)
            S_CLR: begin
                o_cw.we  = 1'b1;
                o_cw.wa  = w_acc;
                // Read ports are off, so A=0: INC seeds 1, PASSA seeds 0.
                o_cw.alu = w_pow2 ? ALU_INC : ALU_PASSA;
            end
            S_LDA: begin
                o_cw.ie = 1'b1;
                o_cw.we = 1'b1;
                o_cw.wa = R1;
            end
            S_LDN: begin
                o_cw.ie  = 1'b1;
                o_cw.we  = 1'b1;
                o_cw.wa  = R0;
                o_ld_idx = i_op == OP_MULT;
            end
            S_BODY: begin
                o_cw.we  = 1'b1;
                o_cw.wa  = w_acc;
                o_cw.rae = 1'b1;
                o_cw.raa = w_acc;
                o_cw.rbe = !w_pow2;
                o_cw.rba = i_op == OP_MULT ? R1 : R0;
                o_cw.alu = w_pow2 ? ALU_PASSA : ALU_ADD;
                o_cw.sh  = w_pow2 ? SH_SHL : SH_PASS;
            end
            S_DEC: begin
                o_cw.we  = 1'b1;
                o_cw.wa  = R0;
                o_cw.rae = 1'b1;
                o_cw.raa = R0;
                o_cw.alu = ALU_DEC;
            end
            S_OUT: begin
                o_cw.oe  = 1'b1;
                o_cw.rae = 1'b1;
                o_cw.raa = w_acc;
                o_cw.alu = ALU_PASSA;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gdp_seq.sv
// gdp_seq: command sequencer driving the general datapath for SUM, MULT and POW2 loops.
//   clk, rst        - clock, async active-high reset
//   start, op       - command strobe and op code (sampled in IDLE)
//   abort           - cancel any running command
//   nEqZero         - datapath write bus equals zero
//   IE..OE          - datapath control word
//   ld_idx          - operand index requested while IE=1
//   busy/done/err   - status
//   iter_cnt        - BODY cycles of the current or last command
module gdp_seq
    import gdp_pkg::*;
#(
    parameter int LOOP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              abort,
    input  logic              nEqZero,
    output logic              IE,
    output logic              WE,
    output logic [1:0]        WA,
    output logic              RAE,
    output logic [1:0]        RAA,
    output logic              RBE,
    output logic [1:0]        RBA,
    output logic [2:0]        ALU,
    output logic [1:0]        SH,
    output logic              OE,
    output logic              ld_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LOOP_W-1:0] iter_cnt
);

    state_t            r_state;
    state_t            w_next;
    op_t               r_op;
    logic [LOOP_W-1:0] r_iter;
    cw_t               w_cw;
    logic              w_accept;

    assign w_accept = r_state == S_IDLE && start && op_t'(op) != OP_ILL;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? (op_t'(op) == OP_ILL ? S_ERR : S_CLR) : S_IDLE;
            S_CLR:   w_next = r_op == OP_MULT ? S_LDA : S_LDN;
            S_LDA:   w_next = S_LDN;
            S_LDN:   w_next = nEqZero ? S_OUT : S_BODY;
            S_BODY:  w_next = S_DEC;
            S_DEC:   w_next = nEqZero ? S_OUT : S_BODY;
            S_OUT:   w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort && r_state != S_IDLE) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= OP_SUM;
            r_iter  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= op_t'(op);
                r_iter <= '0;
            end else if (r_state == S_BODY && r_iter != '1) begin
                r_iter <= r_iter + 1'b1;
            end
        end
    end

    gdp_cw_decode u_dec (
        .i_state  (r_state),
        .i_op     (r_op),
        .o_cw     (w_cw),
        .o_ld_idx (ld_idx)
    );

    assign IE       = w_cw.ie;
    assign WE       = w_cw.we;
    assign WA       = w_cw.wa;
    assign RAE      = w_cw.rae;
    assign RAA      = w_cw.raa;
    assign RBE      = w_cw.rbe;
    assign RBA      = w_cw.rba;
    assign ALU      = w_cw.alu;
    assign SH       = w_cw.sh;
    assign OE       = w_cw.oe;
    assign busy     = r_state != S_IDLE;
    assign done     = r_state == S_OUT || r_state == S_ERR;
    assign err      = r_state == S_ERR;
    assign iter_cnt = r_iter;

endmodule

// File: tb/tb_gdp_seq.sv
// tb_gdp_seq: directed bench for gdp_seq with an 8-bit datapath model attached.
module tb_gdp_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic       abort = 1'b0;
    logic       nEqZero;
    logic       IE, WE, RAE, RBE, OE, ld_idx, busy, done, err;
    logic [1:0] WA, RAA, RBA, SH;
    logic [2:0] ALU;
    logic [7:0] iter_cnt;

    int vectors = 0;
    int miscompares = 0;

    gdp_seq #(.LOOP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .abort(abort), .nEqZero(nEqZero),
        .IE(IE), .WE(WE), .WA(WA), .RAE(RAE), .RAA(RAA), .RBE(RBE), .RBA(RBA),
        .ALU(ALU), .SH(SH), .OE(OE), .ld_idx(ld_idx), .busy(busy), .done(done),
        .err(err), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] rf [4];
    logic [7:0] opa = 8'd0, opb = 8'd0;
    logic [7:0] din, a_bus, b_bus, alu_y, sh_y, wbus, dout;

    assign din   = ld_idx ? opb : opa;
    assign a_bus = RAE ? rf[RAA] : 8'd0;
    assign b_bus = RBE ? rf[RBA] : 8'd0;

    always_comb begin
        case (ALU)
            3'b000:  alu_y = a_bus;
            3'b001:  alu_y = a_bus & b_bus;
            3'b010:  alu_y = a_bus | b_bus;
            3'b011:  alu_y = ~a_bus;
            3'b100:  alu_y = a_bus + b_bus;
            3'b101:  alu_y = a_bus - b_bus;
            3'b110:  alu_y = a_bus + 8'd1;
            default: alu_y = a_bus - 8'd1;
        endcase
        case (SH)
            2'b00:   sh_y = alu_y;
            2'b01:   sh_y = {alu_y[6:0], 1'b0};
            2'b10:   sh_y = {1'b0, alu_y[7:1]};
            default: sh_y = {alu_y[0], alu_y[7:1]};
        endcase
    end

    assign wbus    = IE ? din : sh_y;
    assign nEqZero = wbus == 8'd0;
    assign dout    = OE ? sh_y : 8'd0;

    always @(posedge clk) if (WE) rf[WA] <= wbus;

    int         d_at, e_at;
    logic [7:0] res;
    logic       we_any, ld_first, ld_last;

    // Start is driven at a negedge; the i-th following negedge observes cycle T+i.
    task automatic run(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        logic seen;
        seen = 1'b0;
        opa = a; opb = b;
        d_at = -1; e_at = -1; res = 8'hxx; we_any = 1'b0; ld_first = 1'bx; ld_last = 1'bx;
        @(negedge clk);
        start = 1'b1; op = o;
        for (int i = 1; i <= 60 && d_at < 0; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (WE) we_any = 1'b1;
            if (IE) begin
                if (!seen) ld_first = ld_idx;
                ld_last = ld_idx;
                seen = 1'b1;
            end
            if (err && e_at < 0) e_at = i;
            if (done) begin d_at = i; res = dout; end
        end
    endtask

    task automatic test_reset;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL reset_done_err got %b%b want 00", done, err); end
        vectors++; if ({IE, WE, RAE, RBE, OE} !== 5'b0) begin miscompares++; $display("FAIL reset_cw got %b want 00000", {IE, WE, RAE, RBE, OE}); end
        vectors++; if (iter_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_iter got %0d want 0", iter_cnt); end
    endtask

    task automatic test_sum;
        run(2'b00, 8'd4, 8'd0);
        vectors++; if (d_at !== 11) begin miscompares++; $display("FAIL sum4_done_at got %0d want 11", d_at); end
        vectors++; if (res !== 8'd10) begin miscompares++; $display("FAIL sum4_result got %0d want 10", res); end
        vectors++; if (iter_cnt !== 8'd4) begin miscompares++; $display("FAIL sum4_iter got %0d want 4", iter_cnt); end
        vectors++; if (ld_first !== 1'b0) begin miscompares++; $display("FAIL sum4_ld_idx got %b want 0", ld_first); end
    endtask

    task automatic test_mult;
        run(2'b01, 8'd3, 8'd5);
        vectors++; if (ld_first !== 1'b0 || ld_last !== 1'b1) begin miscompares++; $display("FAIL mult_ld_idx got %b%b want 01", ld_first, ld_last); end
        vectors++; if (d_at !== 14) begin miscompares++; $display("FAIL mult_done_at got %0d want 14", d_at); end
        vectors++; if (res !== 8'd15) begin miscompares++; $display("FAIL mult_result got %0d want 15", res); end
        vectors++; if (iter_cnt !== 8'd5) begin miscompares++; $display("FAIL mult_iter got %0d want 5", iter_cnt); end
    endtask

    task automatic test_pow2;
        run(2'b10, 8'd0, 8'd0);
        vectors++; if (d_at !== 3) begin miscompares++; $display("FAIL pow2_0_done_at got %0d want 3", d_at); end
        vectors++; if (res !== 8'd1) begin miscompares++; $display("FAIL pow2_0_result got %0d want 1", res); end
        vectors++; if (iter_cnt !== 8'd0) begin miscompares++; $display("FAIL pow2_0_iter got %0d want 0", iter_cnt); end
        run(2'b10, 8'd3, 8'd0);
        vectors++; if (res !== 8'd8) begin miscompares++; $display("FAIL pow2_3_result got %0d want 8", res); end
        vectors++; if (d_at !== 9) begin miscompares++; $display("FAIL pow2_3_done_at got %0d want 9", d_at); end
    endtask

    task automatic test_illegal;
        run(2'b11, 8'd7, 8'd7);
        vectors++; if (e_at !== 1 || d_at !== 1) begin miscompares++; $display("FAIL ill_err_done_at got %0d/%0d want 1/1", e_at, d_at); end
        vectors++; if (we_any !== 1'b0) begin miscompares++; $display("FAIL ill_we got %b want 0", we_any); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL ill_t2 got busy%b err%b done%b want 000", busy, err, done); end
    endtask

    task automatic test_back_to_back;
        run(2'b00, 8'd4, 8'd0);
        run(2'b00, 8'd2, 8'd0);
        vectors++; if (d_at !== 7 || res !== 8'd3) begin miscompares++; $display("FAIL b2b_sum2 got at%0d res%0d want at7 res3", d_at, res); end
    endtask

    task automatic test_abort;
        logic saw_done;
        saw_done = 1'b0;
        opa = 8'd6; opb = 8'd0;
        @(negedge clk);
        start = 1'b1; op = 2'b00;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            start = (i == 2);
            op = (i == 2) ? 2'b01 : 2'b00;
            if (done) saw_done = 1'b1;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle got busy %b want 0", busy); end
        vectors++; if (iter_cnt !== 8'd3) begin miscompares++; $display("FAIL abort_iter got %0d want 3", iter_cnt); end
        for (int i = 0; i < 4; i++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        vectors++; if (saw_done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got done%b busy%b want 00", saw_done, busy); end
    endtask

    task automatic test_async_reset;
        opa = 8'd6;
        @(negedge clk);
        start = 1'b1; op = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        vectors++; if (!(WE && RAE && ALU == 3'b111)) begin miscompares++; $display("FAIL rst_pre_dec got we%b rae%b alu%b want 1 1 111", WE, RAE, ALU); end
        #2 rst = 1'b1;
        #1;
        vectors++; if ({busy, WE, RAE, RBE, IE, OE, done, err} !== 8'b0 || ALU !== 3'b0 || WA !== 2'b0 || iter_cnt !== 8'd0) begin
            miscompares++; $display("FAIL rst_async got busy%b we%b alu%b iter%0d want all 0", busy, WE, ALU, iter_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        run(2'b00, 8'd1, 8'd0);
        vectors++; if (d_at !== 5 || res !== 8'd1) begin miscompares++; $display("FAIL rst_sum1 got at%0d res%0d want at5 res1", d_at, res); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset;
        test_sum;
        test_mult;
        test_pow2;
        test_illegal;
        test_back_to_back;
        test_abort;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
